// File: rtl/continuous_monitoring_system_pkg.sv
// rtl/continuous_monitoring_system_pkg.sv - shared types and constants for the trace capture slice
// Used by trace_capture_controller (optional macro TRACE_CAPTURE_ITEM_LIMIT_EN) and trace_item_fifo.
package continuous_monitoring_system_pkg;

    localparam int RISC_V_INSTRUCTION_WIDTH = 32;
    localparam int DEFAULT_PC_WIDTH         = 64;

    typedef enum logic [1:0] {
        CAP_IDLE    = 2'd0,
        CAP_ARMED   = 2'd1,
        CAP_TRACING = 2'd2
    } capture_state_t;

    localparam logic [1:0] CFG_ADDR_CTRL       = 2'd0;
    localparam logic [1:0] CFG_ADDR_START_PC   = 2'd1;
    localparam logic [1:0] CFG_ADDR_STOP_PC    = 2'd2;
    localparam logic [1:0] CFG_ADDR_ITEM_LIMIT = 2'd3;

    localparam int CTRL_ARM_BIT         = 0;
    localparam int CTRL_DISARM_BIT      = 1;
    localparam int CTRL_SINGLE_SHOT_BIT = 2;
    localparam int CTRL_CLR_OVF_BIT     = 3;

    typedef struct packed {
        logic [DEFAULT_PC_WIDTH-1:0]         pc;
        logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    } trace_item_t;

endpackage

// File: rtl/trace_capture_controller_if.sv
// rtl/trace_capture_controller_if.sv - captured trace item output stream (valid/ready)
// master = producer (controller), slave = downstream packer/DMA.
interface trace_capture_controller_if
    import continuous_monitoring_system_pkg::*;
#(
    parameter int PC_WIDTH = 64
);
    logic                                out_valid;
    logic                                out_ready;
    logic [PC_WIDTH-1:0]                 out_pc;
    logic [RISC_V_INSTRUCTION_WIDTH-1:0] out_instr;

    modport master (
        output out_valid,
        output out_pc,
        output out_instr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_pc,
        input  out_instr,
        output out_ready
    );
endinterface

// File: rtl/trace_item_fifo.sv
// rtl/trace_item_fifo.sv - synchronous FIFO of trace items with registered head
// Head is read straight from storage, so it never depends combinationally on the push data.
module trace_item_fifo
    import continuous_monitoring_system_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = trace_item_t
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  push,
    input  item_t push_item,
    input  logic  pop,
    output item_t head,
    output logic  full,
    output logic  empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH) + 1;

    item_t          mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           push_ok;
    logic           pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    // A push into a full FIFO is only legal when the head leaves in the same cycle.
    assign push_ok = push && (!full || pop);
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= push_item;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/trace_capture_controller.sv
// rtl/trace_capture_controller.sv - PC-triggered trace capture FSM, config registers, overflow counter
// Optional macro TRACE_CAPTURE_ITEM_LIMIT_EN enables the ITEM_LIMIT auto-stop.
module trace_capture_controller
    import continuous_monitoring_system_pkg::*;
#(
    parameter int PC_WIDTH               = 64,
    parameter int FIFO_DEPTH             = 4,
    parameter int OVERFLOW_COUNTER_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_wr_en,
    input  logic [1:0]                          cfg_addr,
    input  logic [63:0]                         cfg_wr_data,
    input  logic                                pc_valid,
    input  logic [PC_WIDTH-1:0]                 pc,
    input  logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr,
    input  logic                                drop_instr,
    trace_capture_controller_if.master          out_if,
    output logic [1:0]                          state,
    output logic [OVERFLOW_COUNTER_WIDTH-1:0]   overflow_count
);
    typedef struct packed {
        logic [PC_WIDTH-1:0]                 pc;
        logic [RISC_V_INSTRUCTION_WIDTH-1:0] instr;
    } item_t;

    capture_state_t state_q;
    capture_state_t state_next;
    capture_state_t fsm_next;
    logic [PC_WIDTH-1:0] start_pc;
    logic [PC_WIDTH-1:0] stop_pc;
    logic                single_shot;

    logic   ctrl_wr;
    logic   arm;
    logic   disarm;
    logic   clr_ovf;
    logic   start_hit;
    logic   stop_hit;
    logic   capture;
    logic   entering;
    logic   capture_eff;
    logic   push_ok;
    logic   pop;
    logic   fifo_full;
    logic   fifo_empty;
    logic   limit_stop;
    item_t  push_item;
    item_t  head;

    assign ctrl_wr   = cfg_wr_en && (cfg_addr == CFG_ADDR_CTRL);
    assign arm       = ctrl_wr && cfg_wr_data[CTRL_ARM_BIT];
    assign disarm    = ctrl_wr && cfg_wr_data[CTRL_DISARM_BIT];
    assign clr_ovf   = ctrl_wr && cfg_wr_data[CTRL_CLR_OVF_BIT];
    assign start_hit = pc_valid && (pc == start_pc);
    assign stop_hit  = pc_valid && (pc == stop_pc);

    always_comb begin
        fsm_next = state_q;
        capture  = 1'b0;
        entering = 1'b0;
        case (state_q)
            CAP_IDLE: begin
                if (arm) fsm_next = CAP_ARMED;
            end
            CAP_ARMED: begin
                // Trigger instruction is always captured, whatever the filter says.
                if (start_hit) begin
                    capture  = 1'b1;
                    entering = 1'b1;
                    fsm_next = CAP_TRACING;
                end
            end
            CAP_TRACING: begin
                if (stop_hit) begin
                    capture  = 1'b1;
                    fsm_next = single_shot ? CAP_IDLE : CAP_ARMED;
                end else if (pc_valid && !drop_instr) begin
                    capture = 1'b1;
                end
            end
            default: fsm_next = CAP_IDLE;
        endcase
    end

    assign capture_eff = capture && !disarm;
    assign pop         = out_if.out_valid && out_if.out_ready;
    assign push_ok     = capture_eff && (!fifo_full || pop);

    always_comb begin
        state_next = fsm_next;
        if (limit_stop) state_next = CAP_IDLE;
        if (disarm)     state_next = CAP_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CAP_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_pc    <= '0;
            stop_pc     <= '0;
            single_shot <= 1'b0;
        end else if (cfg_wr_en) begin
            // Trigger addresses may only change while the window is fully closed.
            if (cfg_addr == CFG_ADDR_START_PC && state_q == CAP_IDLE) start_pc <= PC_WIDTH'(cfg_wr_data);
            if (cfg_addr == CFG_ADDR_STOP_PC  && state_q == CAP_IDLE) stop_pc  <= PC_WIDTH'(cfg_wr_data);
            if (cfg_addr == CFG_ADDR_CTRL) single_shot <= cfg_wr_data[CTRL_SINGLE_SHOT_BIT];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_count <= '0;
        end else if (clr_ovf) begin
            overflow_count <= '0;
        end else if (capture_eff && fifo_full && !pop && overflow_count != '1) begin
            overflow_count <= overflow_count + 1'b1;
        end
    end

`ifdef TRACE_CAPTURE_ITEM_LIMIT_EN
    logic [31:0] item_limit;
    logic [31:0] item_count;
    logic [31:0] count_base;
    logic [31:0] count_after;

    // The trigger push happens in the entry cycle, so it is the first item counted.
    assign count_base  = entering ? 32'd0 : item_count;
    assign count_after = count_base + 32'd1;
    assign limit_stop  = push_ok && (item_limit != 32'd0) && (count_after == item_limit);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            item_limit <= '0;
            item_count <= '0;
        end else begin
            if (cfg_wr_en && cfg_addr == CFG_ADDR_ITEM_LIMIT) item_limit <= cfg_wr_data[31:0];
            if (push_ok)       item_count <= count_after;
            else if (entering) item_count <= 32'd0;
        end
    end
`else
    assign limit_stop = 1'b0;
`endif

    assign push_item.pc    = pc;
    assign push_item.instr = instr;

    trace_item_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (item_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (capture_eff),
        .push_item (push_item),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_if.out_valid = !fifo_empty;
    assign out_if.out_pc    = head.pc;
    assign out_if.out_instr = head.instr;
    assign state            = state_q;
endmodule

// File: tb/tb_trace_capture_controller.sv
// tb/tb_trace_capture_controller.sv - directed self-checking bench for trace_capture_controller
// Inputs change and outputs are sampled on the falling edge; the DUT acts on the rising edge.
module tb_trace_capture_controller;
    import continuous_monitoring_system_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_wr_en;
    logic [1:0]  cfg_addr;
    logic [63:0] cfg_wr_data;
    logic        pc_valid;
    logic [63:0] pc;
    logic [31:0] instr;
    logic        drop_instr;
    logic [1:0]  state;
    logic [31:0] overflow_count;
    int          total = 0;
    int          bad   = 0;

    trace_capture_controller_if #(.PC_WIDTH(64)) tif ();

    trace_capture_controller #(
        .PC_WIDTH               (64),
        .FIFO_DEPTH             (4),
        .OVERFLOW_COUNTER_WIDTH (32)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cfg_wr_en      (cfg_wr_en),
        .cfg_addr       (cfg_addr),
        .cfg_wr_data    (cfg_wr_data),
        .pc_valid       (pc_valid),
        .pc             (pc),
        .instr          (instr),
        .drop_instr     (drop_instr),
        .out_if         (tif.master),
        .state          (state),
        .overflow_count (overflow_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] p);
        return {16'hA5A5, p[15:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_write(input logic [1:0] a, input logic [63:0] d);
        cfg_wr_en = 1'b1; cfg_addr = a; cfg_wr_data = d;
        @(negedge clk);
        cfg_wr_en = 1'b0; cfg_addr = 2'd0; cfg_wr_data = '0;
    endtask

    task automatic step_pc(input logic [63:0] p, input logic d);
        pc_valid = 1'b1; pc = p; instr = instr_of(p); drop_instr = d;
        @(negedge clk);
        pc_valid = 1'b0; drop_instr = 1'b0;
    endtask

    // Capture and CTRL write land on the same rising edge.
    task automatic pc_with_ctrl(input logic [63:0] p, input logic [63:0] ctrl);
        cfg_wr_en = 1'b1; cfg_addr = CFG_ADDR_CTRL; cfg_wr_data = ctrl;
        pc_valid = 1'b1; pc = p; instr = instr_of(p); drop_instr = 1'b0;
        @(negedge clk);
        cfg_wr_en = 1'b0; cfg_wr_data = '0; pc_valid = 1'b0;
    endtask

    task automatic pop_expect(input string tag, input logic [63:0] p);
        chk({tag, "_valid"}, {63'd0, tif.out_valid}, 64'd1);
        chk({tag, "_pc"}, tif.out_pc, p);
        chk({tag, "_instr"}, {32'd0, tif.out_instr}, {32'd0, instr_of(p)});
        tif.out_ready = 1'b1;
        @(negedge clk);
        tif.out_ready = 1'b0;
    endtask

    task automatic window_seq();
        step_pc(64'h0FFC, 1'b1);
        step_pc(64'h1000, 1'b1);
        step_pc(64'h1004, 1'b1);
        step_pc(64'h1008, 1'b0);
        step_pc(64'h100C, 1'b1);
        step_pc(64'h1010, 1'b1);
        step_pc(64'h1014, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_wr_data = '0;
        pc_valid = 1'b0; pc = '0; instr = '0; drop_instr = 1'b0; tif.out_ready = 1'b0;
        @(negedge clk);
        chk("rst_state", {62'd0, state}, 64'd0);
        chk("rst_valid", {63'd0, tif.out_valid}, 64'd0);
        chk("rst_pc", tif.out_pc, 64'd0);
        chk("rst_instr", {32'd0, tif.out_instr}, 64'd0);
        chk("rst_ovf", {32'd0, overflow_count}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic window
        cfg_write(CFG_ADDR_START_PC, 64'h1000);
        cfg_write(CFG_ADDR_STOP_PC, 64'h1010);
        cfg_write(CFG_ADDR_CTRL, 64'h1);
        chk("armed", {62'd0, state}, 64'd1);
        step_pc(64'h0FFC, 1'b1);
        chk("pre_trigger_empty", {63'd0, tif.out_valid}, 64'd0);
        step_pc(64'h1000, 1'b1);
        chk("trigger_tracing", {62'd0, state}, 64'd2);
        chk("trigger_visible", {63'd0, tif.out_valid}, 64'd1);
        step_pc(64'h1004, 1'b1);
        step_pc(64'h1008, 1'b0);
        step_pc(64'h100C, 1'b1);
        step_pc(64'h1010, 1'b1);
        chk("stop_rearm", {62'd0, state}, 64'd1);
        step_pc(64'h1014, 1'b1);
        pop_expect("win0", 64'h1000);
        pop_expect("win1", 64'h1008);
        pop_expect("win2", 64'h1010);
        chk("win_drained", {63'd0, tif.out_valid}, 64'd0);

        // Single-shot: second window must be ignored
        cfg_write(CFG_ADDR_CTRL, 64'h5);
        window_seq();
        chk("ss_idle", {62'd0, state}, 64'd0);
        window_seq();
        chk("ss_idle2", {62'd0, state}, 64'd0);
        pop_expect("ss0", 64'h1000);
        pop_expect("ss1", 64'h1008);
        pop_expect("ss2", 64'h1010);
        chk("ss_drained", {63'd0, tif.out_valid}, 64'd0);

        // Overflow, plus STOP_PC write outside IDLE is ignored
        cfg_write(CFG_ADDR_START_PC, 64'h2000);
        cfg_write(CFG_ADDR_STOP_PC, 64'h3000);
        cfg_write(CFG_ADDR_CTRL, 64'h1);
        cfg_write(CFG_ADDR_STOP_PC, 64'h2008);
        for (int i = 0; i < 6; i++) step_pc(64'h2000 + 64'(4 * i), 1'b0);
        chk("ovf_tracing", {62'd0, state}, 64'd2);
        chk("ovf_count2", {32'd0, overflow_count}, 64'd2);
        for (int i = 0; i < 4; i++) pop_expect("ovf_drain", 64'h2000 + 64'(4 * i));
        chk("ovf_drained", {63'd0, tif.out_valid}, 64'd0);

        // Full with simultaneous pop
        for (int i = 0; i < 4; i++) step_pc(64'h2100 + 64'(4 * i), 1'b0);
        tif.out_ready = 1'b1;
        step_pc(64'h2110, 1'b0);
        tif.out_ready = 1'b0;
        chk("fullpop_ovf", {32'd0, overflow_count}, 64'd2);
        for (int i = 1; i < 5; i++) pop_expect("fullpop", 64'h2100 + 64'(4 * i));
        chk("fullpop_drained", {63'd0, tif.out_valid}, 64'd0);

        // Clear wins over increment, then saturating counter restarts from 0
        for (int i = 0; i < 4; i++) step_pc(64'h2200 + 64'(4 * i), 1'b0);
        pc_with_ctrl(64'h2210, 64'h8);
        chk("clr_wins", {32'd0, overflow_count}, 64'd0);
        step_pc(64'h2214, 1'b0);
        chk("ovf_after_clr", {32'd0, overflow_count}, 64'd1);
        for (int i = 0; i < 4; i++) pop_expect("clr_drain", 64'h2200 + 64'(4 * i));

        // Disarm mid-trace
        step_pc(64'h2300, 1'b0);
        step_pc(64'h2304, 1'b0);
        pc_with_ctrl(64'h2308, 64'h2);
        chk("disarm_idle", {62'd0, state}, 64'd0);
        pop_expect("disarm0", 64'h2300);
        pop_expect("disarm1", 64'h2304);
        chk("disarm_drained", {63'd0, tif.out_valid}, 64'd0);
        cfg_write(CFG_ADDR_CTRL, 64'h3);
        chk("arm_disarm_idle", {62'd0, state}, 64'd0);

        // Asynchronous reset mid-cycle with full FIFO
        cfg_write(CFG_ADDR_START_PC, 64'h4000);
        cfg_write(CFG_ADDR_CTRL, 64'h1);
        for (int i = 0; i < 4; i++) step_pc(64'h4000 + 64'(4 * i), 1'b0);
        chk("pre_rst_tracing", {62'd0, state}, 64'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", {63'd0, tif.out_valid}, 64'd0);
        chk("arst_state", {62'd0, state}, 64'd0);
        chk("arst_pc", tif.out_pc, 64'd0);
        chk("arst_ovf", {32'd0, overflow_count}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // START_PC == STOP_PC: one match starts, the next stops
        cfg_write(CFG_ADDR_START_PC, 64'h5000);
        cfg_write(CFG_ADDR_STOP_PC, 64'h5000);
        cfg_write(CFG_ADDR_CTRL, 64'h1);
        step_pc(64'h5000, 1'b0);
        chk("eq_start", {62'd0, state}, 64'd2);
        step_pc(64'h5004, 1'b0);
        step_pc(64'h5000, 1'b0);
        chk("eq_stop", {62'd0, state}, 64'd1);
        pop_expect("eq0", 64'h5000);
        pop_expect("eq1", 64'h5004);
        pop_expect("eq2", 64'h5000);
        chk("eq_drained", {63'd0, tif.out_valid}, 64'd0);

`ifdef TRACE_CAPTURE_ITEM_LIMIT_EN
        cfg_write(CFG_ADDR_CTRL, 64'h2);
        cfg_write(CFG_ADDR_START_PC, 64'h6000);
        cfg_write(CFG_ADDR_STOP_PC, 64'h7000);
        cfg_write(CFG_ADDR_ITEM_LIMIT, 64'd3);
        cfg_write(CFG_ADDR_CTRL, 64'h1);
        step_pc(64'h6000, 1'b0);
        step_pc(64'h6004, 1'b0);
        chk("lim_tracing", {62'd0, state}, 64'd2);
        step_pc(64'h6008, 1'b0);
        chk("lim_idle", {62'd0, state}, 64'd0);
        step_pc(64'h600C, 1'b0);
        for (int i = 0; i < 3; i++) pop_expect("lim", 64'h6000 + 64'(4 * i));
        chk("lim_drained", {63'd0, tif.out_valid}, 64'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
